buffer_drain: RTL and testbench
===============================

# buffer_drain

Downstream read stage for the four destination buffers filled by the input-capture stage. Each cycle it picks one non-empty buffer in round-robin order, pops its head entry, and presents it with its buffer ID on a single valid/ready output port. It also keeps a saturating count of entries served per buffer, readable through a select port. It is the "read data" step between capture and the shift/arrange stage.

## Interface

Parameters:
- PAYLOAD_W, 2, payload bits per buffer entry
- CNT_W, 8, width of each per-buffer served counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- buf_valid  in  4  bit k = buffer k head entry is valid (non-empty)
- buf_data  in  4*PAYLOAD_W  head payload of buffer k at bits [k*PAYLOAD_W +: PAYLOAD_W]
- buf_pop  out  4  one-hot or zero; bit k = buffer k removes its head at this clock edge
- out_valid  out  1  out_data holds an entry
- out_ready  in  1  consumer accepts out_data this cycle when out_valid=1
- out_data  out  PAYLOAD_W+2  {buffer_id[1:0], payload}
- cnt_sel  in  2  selects which served counter drives cnt_value
- cnt_value  out  CNT_W  served counter of buffer cnt_sel (combinational mux of registers)
- cnt_clr  in  1  synchronous clear of all four served counters

## Operation

- Output register state machine, states EMPTY (out_valid=0) and FULL (out_valid=1).
- load = (buf_valid != 0) && (EMPTY || out_ready).
- EMPTY: load -> FULL with granted entry; no load -> stay EMPTY.
- FULL: out_ready && load -> stay FULL, new entry replaces old (back-to-back); out_ready && !load -> EMPTY; !out_ready -> hold, out_data stable, no pop.
- Arbitration: pointer last[1:0]; search order last+1, last+2, last+3, last (mod 4); first buffer with buf_valid=1 is granted. On load, last <= granted index. Pointer is unchanged when nothing loads.
- buf_pop: combinational, asserted only in a load cycle, one-hot at the granted index; 0 otherwise and 0 while rst=1.
- On load: out_data <= {granted index, buf_data slice of granted index}.
- Served counters: cnt[k] increments by 1 on each cycle with buf_pop[k]=1, saturating at 2^CNT_W-1 (no wrap). cnt_clr=1 sets all counters to 0; clear wins over a same-cycle pop (result 0).
- Payload is passed through unmodified; no width conversion.

## Timing

- Reset (async assert, takes effect without clk): out_valid=0, out_data=0, last=3 (first search starts at buffer 0), all counters 0, buf_pop=0, cnt_value=0.
- Latency: buf_valid seen with stage EMPTY in cycle N -> buf_pop in cycle N, out_valid=1 with data in cycle N+1.
- Throughput: 1 entry/cycle with out_ready held high and any buffer non-empty.
- out_data and out_valid change only at clock edges. They must be held stable while out_valid=1 && out_ready=0.
- buf_valid changes while stalled have no effect until the next load cycle.
- Reset mid-transfer: the held entry is discarded (it was already popped). No pop is issued in the reset cycle.
- cnt_value reflects a pop or clear in the cycle after the edge that applied it.

## Test plan

- Reset then buf_valid=4'b0001, buf_data[1:0]=2'b10, out_ready=1 -> buf_pop=0001 same cycle. Next cycle out_valid=1, out_data=4'b0010, cnt_value(sel 0)=1.
- All four valid continuously, payload k=k, out_ready=1 -> grants 0,1,2,3,0,… one per cycle, out_data=0000,0101,1010,1111 repeating.
- FULL with out_ready=0 for 5 cycles while buf_valid=1111 -> buf_pop=0 throughout, out_data unchanged. On out_ready=1, the next grant follows the round-robin order from the held ID.
- Only buffer 2 valid for 300 pops with CNT_W=8 -> cnt[2] saturates at 255. Then cnt_clr=1 with a simultaneous pop -> cnt[2]=0.
- Assert rst while FULL with buf_valid=1111 -> out_valid=0 immediately, buf_pop=0. After release, the first grant is buffer 0.
- buf_valid=1010 with last=1 -> grant buffer 3, then buffer 1, then buffer 3. Buffers 0 and 2 are never popped.

Source files
------------

// File: rtl/buffer_drain_if.sv
// Signal bundle between the four capture buffers, the drain stage and its consumer.
// The master modport is the drain stage; the slave modport is the surrounding logic.
interface buffer_drain_if #(
  parameter int PAYLOAD_W = 2,
  parameter int CNT_W     = 8
);
  logic [3:0]             buf_valid;
  logic [4*PAYLOAD_W-1:0] buf_data;
  logic [3:0]             buf_pop;
  logic                   out_valid;
  logic                   out_ready;
  logic [PAYLOAD_W+1:0]   out_data;
  logic [1:0]             cnt_sel;
  logic [CNT_W-1:0]       cnt_value;
  logic                   cnt_clr;

  modport master (
    input  buf_valid, buf_data, out_ready, cnt_sel, cnt_clr,
    output buf_pop, out_valid, out_data, cnt_value
  );

  modport slave (
    output buf_valid, buf_data, out_ready, cnt_sel, cnt_clr,
    input  buf_pop, out_valid, out_data, cnt_value
  );
endinterface

// File: rtl/buffer_drain.sv
// Round-robin drain of four buffers into one registered valid/ready port with per-buffer served counters.
// Pop in the load cycle, data valid one cycle later; a stalled output holds its entry and pops nothing.
module buffer_drain #(
  parameter int PAYLOAD_W = 2,
  parameter int CNT_W     = 8
) (
  input logic            clk,
  input logic            rst,
  buffer_drain_if.master bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                 state, state_nxt;
  logic [1:0]             last;
  logic [PAYLOAD_W+1:0]   data_q;
  logic [CNT_W-1:0]       cnt [4];
  logic [PAYLOAD_W-1:0]   head [4];
  logic [1:0]             gnt_idx;
  logic [1:0]             cand;
  logic                   gnt_found;
  logic                   load;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      head[k] = bus.buf_data[k*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  // Search starts just after the last granted buffer and ends on it.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = last;
    cand      = last;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!gnt_found && bus.buf_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign load = gnt_found && ((state == EMPTY) || bus.out_ready);

  always_comb begin
    state_nxt   = state;
    bus.buf_pop = 4'b0000;
    if (load) begin
      state_nxt = FULL;
    end else if ((state == FULL) && bus.out_ready) begin
      state_nxt = EMPTY;
    end
    if (load && !rst) begin
      bus.buf_pop[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      last   <= 2'd3;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        last   <= gnt_idx;
        data_q <= {gnt_idx, head[gnt_idx]};
      end
    end
  end

  // Clear takes priority over a same-cycle pop; counts stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (bus.cnt_clr) begin
          cnt[k] <= '0;
        end else if (bus.buf_pop[k] && (cnt[k] != {CNT_W{1'b1}})) begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_q;
  assign bus.cnt_value = cnt[bus.cnt_sel];

endmodule

// File: tb/tb_buffer_drain.sv
// Directed and random stimulus for buffer_drain, checked against a transaction-level reference model.
module tb_buffer_drain;

  localparam int PW  = 2;
  localparam int CW  = 8;
  localparam int MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  int   nvec  = 0;
  int   nfail = 0;

  buffer_drain_if #(.PAYLOAD_W(PW), .CNT_W(CW)) bus ();

  buffer_drain #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit  m_full;
  int  m_last;
  int  m_data;
  int  m_cnt [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_last = 3;
    m_data = 0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
  endtask

  // Called just after a falling edge; applies one cycle of inputs and checks that cycle.
  task automatic step(input logic [3:0] v, input logic [7:0] d, input logic rdy,
                      input logic clr, input logic [1:0] sel, input string tag);
    int  g;
    bit  ld;
    int  exp_pop;
    bus.buf_valid = v;
    bus.buf_data  = d;
    bus.out_ready = rdy;
    bus.cnt_clr   = clr;
    bus.cnt_sel   = sel;
    #1;
    g = -1;
    for (int i = 1; i <= 4; i++) begin
      if (g < 0 && v[(m_last + i) % 4]) g = (m_last + i) % 4;
    end
    ld      = (g >= 0) && (!m_full || rdy);
    exp_pop = ld ? (1 << g) : 0;
    check({tag, ".pop"},       32'(bus.buf_pop),   32'(exp_pop));
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_full));
    check({tag, ".out_data"},  32'(bus.out_data),  32'(m_data));
    check({tag, ".cnt_value"}, 32'(bus.cnt_value), 32'(m_cnt[sel]));
    @(posedge clk);
    if (ld) begin
      m_full = 1'b1;
      m_data = (g << PW) | ((d >> (g * PW)) & 3);
      m_last = g;
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      if (clr) m_cnt[k] = 0;
      else if (ld && g == k && m_cnt[k] < MAX) m_cnt[k] = m_cnt[k] + 1;
    end
    @(negedge clk);
  endtask

  initial begin
    bus.buf_valid = '0;
    bus.buf_data  = '0;
    bus.out_ready = 1'b0;
    bus.cnt_clr   = 1'b0;
    bus.cnt_sel   = 2'd0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    bus.buf_valid = 4'b1111;
    #1;
    check("reset.out_valid", 32'(bus.out_valid), 32'd0);
    check("reset.out_data",  32'(bus.out_data),  32'd0);
    check("reset.pop",       32'(bus.buf_pop),   32'd0);
    check("reset.cnt_value", 32'(bus.cnt_value), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single entry from buffer 0
    step(4'b0001, 8'b0000_0010, 1'b1, 1'b0, 2'd0, "single");
    step(4'b0000, 8'h00,        1'b1, 1'b0, 2'd0, "single_out");
    check("single.data_direct", 32'(bus.out_data), 32'b0010);

    // All four valid, payload k in slot k: grants 0,1,2,3 repeating
    for (int i = 0; i < 9; i++) step(4'b1111, 8'b11_10_01_00, 1'b1, 1'b0, 2'(i), "rr_all");

    // Stall with everything valid
    for (int i = 0; i < 5; i++) step(4'b1111, 8'($urandom), 1'b0, 1'b0, 2'd1, "stall");
    for (int i = 0; i < 3; i++) step(4'b1111, 8'b11_10_01_00, 1'b1, 1'b0, 2'd1, "stall_release");

    // Saturation of buffer 2, then clear against a concurrent pop
    for (int i = 0; i < 300; i++) step(4'b0100, 8'($urandom), 1'b1, 1'b0, 2'd2, "sat");
    check("sat.cnt2", 32'(bus.cnt_value), 32'(MAX));
    step(4'b0100, 8'($urandom), 1'b1, 1'b1, 2'd2, "sat_clr");
    step(4'b0000, 8'h00,        1'b1, 1'b0, 2'd2, "after_clr");

    // Asynchronous reset while holding an entry
    step(4'b1111, 8'b11_10_01_00, 1'b0, 1'b0, 2'd0, "pre_rst");
    step(4'b1111, 8'b11_10_01_00, 1'b0, 1'b0, 2'd0, "pre_rst_hold");
    rst = 1'b1;
    #1;
    check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst.pop",       32'(bus.buf_pop),   32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(4'b1111, 8'b11_10_01_00, 1'b1, 1'b0, 2'd0, "post_rst");

    // Leave pointer at 1, then only buffers 1 and 3 valid
    step(4'b1111, 8'b11_10_01_00, 1'b1, 1'b0, 2'd1, "to_last1");
    for (int i = 0; i < 4; i++) step(4'b1010, 8'b11_10_01_00, 1'b1, 1'b0, 2'(i), "alt13");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 40) == 0), 2'($urandom), "rand");
    end
    step(4'b0000, 8'h00, 1'b1, 1'b0, 2'd0, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
